npu_config_loader: RTL and testbench

- Upstream feeder of the NPU scheduler and PE weight ports.
- Parses one configuration packet from the config FIFO read interface: header words, then weight words routed round-robin to PEs, then schedule words.
- Writes schedule words into the scheduler circular buffer through npu_sched_write_en/npu_sched_din.
- Reports done/error status to the NPU controller.

---
 rtl/npu_config_loader.sv | 190 +++++++++++++++++++
 tb/tb_npu_config_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_config_loader.sv
// ---------------------------------------------------------------------------
// npu_config_loader
//
// Reads one configuration packet from the config FIFO. The packet has two
// header words, then W weight words that go round-robin to the PEs, then
// N schedule words that go to the scheduler circular buffer. Completion or a
// malformed header is reported through sticky done/error flags.
//
// Packet layout:
//   word 0 : [15:12] magic 4'hA, [10:0] N (schedule length, 1..SCHED_DEPTH)
//   word 1 : [11:0]  W (weight count, 0..MAX_WEIGHTS)
//   W weight words, then N schedule words
//
// Handshake: a config word is transferred on any rising CLK edge where
// npu_cfg_valid and npu_cfg_ready are both high. npu_cfg_ready is
// combinational from the FSM state and npu_state_compute only. It never
// depends on npu_cfg_valid. The FIFO may hold valid high for as long as it
// likes. A word that is not accepted must stay stable until it is accepted.
//
// Ports:
//   CLK                     clock
//   npu_rst                 asynchronous active-high reset
//   npu_cfg_start           pulse, starts a packet load (IDLE/DONE/ERR only)
//   npu_state_compute       NPU compute phase, stalls the loader
//   npu_cfg_valid/din       config FIFO word
//   npu_cfg_ready           word accepted this cycle when valid & ready
//   npu_sched_write_en/din  scheduler buffer write (registered)
//   npu_cfg_weight_*        PE weight write (registered)
//   npu_cfg_busy            load in progress (HDR0..SCHED)
//   npu_cfg_done            packet loaded, sticky until next start
//   npu_cfg_error           malformed header, sticky until next start
// ---------------------------------------------------------------------------
module npu_config_loader #(
    parameter int SCHED_DEPTH = 1024,
    parameter int NUM_PE      = 8,
    parameter int MAX_WEIGHTS = 4095
) (
    input  logic        CLK,
    input  logic        npu_rst,
    input  logic        npu_cfg_start,
    input  logic        npu_state_compute,
    input  logic        npu_cfg_valid,
    input  logic [15:0] npu_cfg_din,
    output logic        npu_cfg_ready,
    output logic        npu_sched_write_en,
    output logic [15:0] npu_sched_din,
    output logic        npu_cfg_weight_write_en,
    output logic [2:0]  npu_cfg_weight_pe_sel,
    output logic [15:0] npu_cfg_weight_dout,
    output logic        npu_cfg_busy,
    output logic        npu_cfg_done,
    output logic        npu_cfg_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_WEIGHTS,
        S_SCHED,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] PE_LAST = 3'(NUM_PE - 1);

    state_t      state;
    logic [10:0] n_len;     // schedule length latched from header 0
    logic [11:0] w_len;     // weight count latched from header 1
    logic [11:0] w_cnt;     // weights accepted so far
    logic [10:0] s_cnt;     // schedule words accepted so far
    logic [2:0]  pe_cnt;    // PE that receives the next weight

    logic        acc;
    logic [3:0]  hdr_magic;
    logic [10:0] hdr_n;
    logic [11:0] hdr_w;
    logic        hdr0_bad;
    logic        hdr1_bad;

    assign npu_cfg_ready = ~npu_state_compute &
                           ((state == S_HDR0) || (state == S_HDR1) ||
                            (state == S_WEIGHTS) || (state == S_SCHED));
    assign acc = npu_cfg_valid & npu_cfg_ready;

    assign hdr_magic = npu_cfg_din[15:12];
    assign hdr_n     = npu_cfg_din[10:0];
    assign hdr_w     = npu_cfg_din[11:0];
    assign hdr0_bad  = (hdr_magic != 4'hA) || (hdr_n == 11'd0) ||
                       (int'(hdr_n) > SCHED_DEPTH);
    assign hdr1_bad  = (int'(hdr_w) > MAX_WEIGHTS);

    always_ff @(posedge CLK or posedge npu_rst) begin
        if (npu_rst) begin
            state                   <= S_IDLE;
            n_len                   <= '0;
            w_len                   <= '0;
            w_cnt                   <= '0;
            s_cnt                   <= '0;
            pe_cnt                  <= '0;
            npu_sched_write_en      <= 1'b0;
            npu_sched_din           <= '0;
            npu_cfg_weight_write_en <= 1'b0;
            npu_cfg_weight_pe_sel   <= '0;
            npu_cfg_weight_dout     <= '0;
            npu_cfg_busy            <= 1'b0;
            npu_cfg_done            <= 1'b0;
            npu_cfg_error           <= 1'b0;
        end else begin
            // Write strobes last one cycle per accepted word. The data
            // registers keep their last value.
            npu_sched_write_en      <= 1'b0;
            npu_cfg_weight_write_en <= 1'b0;

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (npu_cfg_start && !npu_state_compute) begin
                        state         <= S_HDR0;
                        npu_cfg_busy  <= 1'b1;
                        npu_cfg_done  <= 1'b0;
                        npu_cfg_error <= 1'b0;
                        n_len         <= '0;
                        w_len         <= '0;
                        w_cnt         <= '0;
                        s_cnt         <= '0;
                        pe_cnt        <= '0;
                    end
                end

                S_HDR0: begin
                    if (acc) begin
                        if (hdr0_bad) begin
                            state         <= S_ERR;
                            npu_cfg_busy  <= 1'b0;
                            npu_cfg_error <= 1'b1;
                        end else begin
                            n_len <= hdr_n;
                            state <= S_HDR1;
                        end
                    end
                end

                S_HDR1: begin
                    if (acc) begin
                        if (hdr1_bad) begin
                            state         <= S_ERR;
                            npu_cfg_busy  <= 1'b0;
                            npu_cfg_error <= 1'b1;
                        end else begin
                            w_len <= hdr_w;
                            state <= (hdr_w == 12'd0) ? S_SCHED : S_WEIGHTS;
                        end
                    end
                end

                S_WEIGHTS: begin
                    if (acc) begin
                        npu_cfg_weight_write_en <= 1'b1;
                        npu_cfg_weight_dout     <= npu_cfg_din;
                        npu_cfg_weight_pe_sel   <= pe_cnt;
                        pe_cnt <= (pe_cnt == PE_LAST) ? 3'd0 : pe_cnt + 3'd1;
                        w_cnt  <= w_cnt + 12'd1;
                        if (w_cnt == w_len - 12'd1) begin
                            state <= S_SCHED;
                        end
                    end
                end

                S_SCHED: begin
                    if (acc) begin
                        npu_sched_write_en <= 1'b1;
                        npu_sched_din      <= npu_cfg_din;
                        s_cnt              <= s_cnt + 11'd1;
                        // done becomes visible together with the final strobe
                        if (s_cnt == n_len - 11'd1) begin
                            state        <= S_DONE;
                            npu_cfg_busy <= 1'b0;
                            npu_cfg_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_config_loader.sv
module tb_npu_config_loader;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        npu_rst = 1'b1;
    logic        npu_cfg_start = 1'b0;
    logic        npu_state_compute = 1'b0;
    logic        npu_cfg_valid = 1'b0;
    logic [15:0] npu_cfg_din = 16'h0;
    logic        npu_cfg_ready;
    logic        npu_sched_write_en;
    logic [15:0] npu_sched_din;
    logic        npu_cfg_weight_write_en;
    logic [2:0]  npu_cfg_weight_pe_sel;
    logic [15:0] npu_cfg_weight_dout;
    logic        npu_cfg_busy;
    logic        npu_cfg_done;
    logic        npu_cfg_error;

    always #5 CLK = ~CLK;

    npu_config_loader #(.SCHED_DEPTH(1024), .NUM_PE(8), .MAX_WEIGHTS(4095)) dut (
        .CLK                     (CLK),
        .npu_rst                 (npu_rst),
        .npu_cfg_start           (npu_cfg_start),
        .npu_state_compute       (npu_state_compute),
        .npu_cfg_valid           (npu_cfg_valid),
        .npu_cfg_din             (npu_cfg_din),
        .npu_cfg_ready           (npu_cfg_ready),
        .npu_sched_write_en      (npu_sched_write_en),
        .npu_sched_din           (npu_sched_din),
        .npu_cfg_weight_write_en (npu_cfg_weight_write_en),
        .npu_cfg_weight_pe_sel   (npu_cfg_weight_pe_sel),
        .npu_cfg_weight_dout     (npu_cfg_weight_dout),
        .npu_cfg_busy            (npu_cfg_busy),
        .npu_cfg_done            (npu_cfg_done),
        .npu_cfg_error           (npu_cfg_error)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    // weight entry: {idx[10:0], pe[2:0], data[15:0]}; sched entry: {idx[10:0], data[15:0]}
    logic [31:0] exp_w_q[$];
    logic [31:0] exp_s_q[$];
    logic [15:0] pkt[$];
    int          acc_cyc[0:2047];
    int          n_present;     // number of packet words the loader consumes
    logic        exp_done;
    logic        exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: parse the packet by the format rules directly.
    task automatic build_exp();
        int n, w;
        exp_w_q.delete();
        exp_s_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = int'(pkt[0] & 16'h07FF);
        if ((pkt[0] >> 12) != 16'hA || n == 0 || n > 1024) begin
            exp_err   = 1'b1;
            n_present = 1;
            return;
        end
        w = int'(pkt[1] & 16'h0FFF);
        if (w > 4095) begin
            exp_err   = 1'b1;
            n_present = 2;
            return;
        end
        for (int i = 0; i < w; i++)
            exp_w_q.push_back({5'd0, 11'(2 + i), 3'(i % 8), pkt[2 + i]});
        for (int i = 0; i < n; i++)
            exp_s_q.push_back({5'd0, 11'(2 + w + i), pkt[2 + w + i]});
        exp_done  = 1'b1;
        n_present = 2 + w + n;
    endtask

    // Strobe monitor: content, PE index, one-cycle latency, done alignment.
    always @(negedge CLK) begin
        if (!npu_rst) begin
            if (npu_cfg_weight_write_en) begin
                if (exp_w_q.size() == 0) begin
                    chk("weight_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_w_q.pop_front();
                    chk("weight_pe", 32'(npu_cfg_weight_pe_sel), 32'(e[18:16]));
                    chk("weight_data", 32'(npu_cfg_weight_dout), 32'(e[15:0]));
                    chk("weight_latency", 32'(cyc), 32'(acc_cyc[e[29:19]] + 1));
                end
            end
            if (npu_sched_write_en) begin
                if (exp_s_q.size() == 0) begin
                    chk("sched_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_s_q.pop_front();
                    chk("sched_data", 32'(npu_sched_din), 32'(e[15:0]));
                    chk("sched_latency", 32'(cyc), 32'(acc_cyc[e[26:16]] + 1));
                    chk("done_at_strobe", 32'(npu_cfg_done), (exp_s_q.size() == 0) ? 32'd1 : 32'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [15:0] w, input int idx, input int gap);
        int n;
        repeat (gap) begin
            @(negedge CLK);
            npu_cfg_valid = 1'b0;
        end
        @(negedge CLK);
        npu_cfg_valid = 1'b1;
        npu_cfg_din   = w;
        #1;
        n = 0;
        while (!npu_cfg_ready && n < 100) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (!npu_cfg_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        acc_cyc[idx] = cyc;   // accept edge is the next posedge
        @(posedge CLK);
    endtask

    task automatic bus_idle();
        @(negedge CLK);
        npu_cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        npu_cfg_start = 1'b1;
        @(negedge CLK);
        npu_cfg_start = 1'b0;
    endtask

    task automatic finish_check(input string tag);
        int n;
        n = 0;
        while (!(npu_cfg_done || npu_cfg_error) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        repeat (2) @(negedge CLK);
        chk({tag, "_done"}, 32'(npu_cfg_done), 32'(exp_done));
        chk({tag, "_error"}, 32'(npu_cfg_error), 32'(exp_err));
        chk({tag, "_busy"}, 32'(npu_cfg_busy), 32'd0);
        chk({tag, "_ready"}, 32'(npu_cfg_ready), 32'd0);
        chk({tag, "_w_left"}, 32'(exp_w_q.size()), 32'd0);
        chk({tag, "_s_left"}, 32'(exp_s_q.size()), 32'd0);
    endtask

    task automatic run_pkt(input string tag, input int gap_max);
        build_exp();
        pulse_start();
        chk({tag, "_busy_start"}, 32'(npu_cfg_busy), 32'd1);
        chk({tag, "_flags_clear"}, {30'd0, npu_cfg_done, npu_cfg_error}, 32'd0);
        for (int i = 0; i < n_present; i++)
            send_word(pkt[i], i, $urandom_range(0, gap_max));
        bus_idle();
        finish_check(tag);
    endtask

    task automatic rand_pkt(input int n, input int w);
        pkt.delete();
        pkt.push_back(16'hA000 | 16'(n) | (16'($urandom_range(0, 1)) << 11));
        pkt.push_back(16'(w) | (16'($urandom_range(0, 15)) << 12));
        for (int i = 0; i < w + n; i++) pkt.push_back(16'($urandom));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_outputs", {23'd0, npu_cfg_ready, npu_sched_write_en, npu_cfg_weight_write_en,
                            npu_cfg_busy, npu_cfg_done, npu_cfg_error, npu_cfg_weight_pe_sel == 3'd0,
                            npu_sched_din == 16'd0, npu_cfg_weight_dout == 16'd0}, 32'h7);
        npu_rst = 1'b0;
        repeat (2) @(negedge CLK);
        chk("idle_ready", 32'(npu_cfg_ready), 32'd0);

        // basic packet: 3 weights, 4 schedule words, continuous valid
        pkt = '{16'hA004, 16'h0003, 16'h1111, 16'h2222, 16'h3333,
                16'h0081, 16'h0102, 16'h0204, 16'h4308};
        run_pkt("basic", 0);

        // ten weights: PE index wraps after 7
        rand_pkt(1, 10);
        run_pkt("wrap10", 0);

        // bad headers: magic, N=0, N=1025
        pkt = '{16'h5004};
        run_pkt("bad_magic", 0);
        pkt = '{16'hA000};
        run_pkt("n_zero", 0);
        pkt = '{16'hA401};
        run_pkt("n_1025", 0);

        // valid toggling in SCHED, N=3, W=0
        pkt = '{16'hA003, 16'h0000, 16'hBEEF, 16'h1234, 16'hCAFE};
        build_exp();
        pulse_start();
        send_word(pkt[0], 0, 0);
        send_word(pkt[1], 1, 0);
        for (int i = 2; i < 5; i++) send_word(pkt[i], i, 1);
        bus_idle();
        finish_check("toggle");

        // compute stall during WEIGHTS, start while busy ignored
        rand_pkt(2, 5);
        build_exp();
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(pkt[i], i, 0);
        @(negedge CLK);
        npu_state_compute = 1'b1;
        npu_cfg_valid     = 1'b1;
        npu_cfg_din       = pkt[4];
        #1;
        chk("stall_ready", 32'(npu_cfg_ready), 32'd0);
        repeat (4) begin
            @(negedge CLK);
            chk("stall_no_weight", 32'(npu_cfg_weight_write_en), 32'd0);
            chk("stall_busy", 32'(npu_cfg_busy), 32'd1);
        end
        npu_cfg_start = 1'b1;
        @(negedge CLK);
        npu_state_compute = 1'b0;
        npu_cfg_valid     = 1'b0;
        @(negedge CLK);
        npu_cfg_start = 1'b0;
        chk("start_busy_ignored", 32'(npu_cfg_busy), 32'd1);
        for (int i = 4; i < n_present; i++) send_word(pkt[i], i, 0);
        bus_idle();
        finish_check("stall");

        // reset in the middle of SCHED after 2 of 4 words
        rand_pkt(4, 0);
        build_exp();
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(pkt[i], i, 0);
        @(negedge CLK);
        npu_cfg_valid = 1'b0;
        #2;
        npu_rst = 1'b1;
        #1;
        chk("midrst_outputs", {24'd0, npu_cfg_ready, npu_sched_write_en, npu_cfg_weight_write_en,
                               npu_cfg_busy, npu_cfg_done, npu_cfg_error,
                               npu_sched_din == 16'd0, npu_cfg_weight_dout == 16'd0}, 32'h3);
        exp_w_q.delete();
        exp_s_q.delete();
        repeat (2) @(negedge CLK);
        npu_rst = 1'b0;
        repeat (4) @(negedge CLK);
        chk("midrst_idle", {29'd0, npu_cfg_busy, npu_cfg_done, npu_cfg_error}, 32'd0);
        rand_pkt(4, 2);
        run_pkt("reload", 0);

        // randomized packets with random gaps
        for (int k = 0; k < 5; k++) begin
            rand_pkt($urandom_range(1, 8), $urandom_range(0, 12));
            run_pkt("random", 2);
        end

        // maximum schedule length, no weights
        rand_pkt(1024, 0);
        run_pkt("n_1024", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
